usb_tx_sequencer: RTL and testbench

- Parametrised next-generation transmit sequencer for the USB encryptor datapath.
- Pulls PID, non-data (token/SOF) bytes, payload bytes and data-CRC bytes from four show-ahead byte FIFOs.
- Emits SYNC, PID, body and CRC bytes to the byte serializer over a valid/ready handshake, then requests EOP.
- Adds PID validation, configurable payload length, FIFO-underrun abort and inter-packet gap; the serializer handshake replaces fixed per-byte wait counters.

---
 rtl/usb_tx_sequencer.sv | 177 +++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// USB transmit sequencer: fetches PID/body/CRC bytes from show-ahead FIFOs and streams SYNC..CRC then EOP.
// Define TX_SEQ_PKT_COUNT_EN to build the completed-packet counter; otherwise pkt_count is tied to zero.
module usb_tx_sequencer #(
  parameter int         PAYLOAD_BYTES = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'h80,
  parameter int         IPG_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_req,
  input  logic        pid_empty,
  input  logic [7:0]  pid_data,
  output logic        pid_pop,
  input  logic        nd_empty,
  input  logic [7:0]  nd_data,
  output logic        nd_pop,
  input  logic        data_empty,
  input  logic [7:0]  data_data,
  output logic        data_pop,
  input  logic        crc_empty,
  input  logic [7:0]  crc_data,
  output logic        crc_pop,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_eop,
  input  logic        eop_done,
  output logic        busy,
  output logic        pid_err,
  output logic        underrun_err,
  output logic [15:0] pkt_count
);

  // Counter must also hold the 2-byte ND/CRC lengths when PAYLOAD_BYTES is 1.
  localparam int RW_RAW = $clog2(PAYLOAD_BYTES + 1);
  localparam int RW     = (RW_RAW < 2) ? 2 : RW_RAW;
  localparam logic [RW-1:0] REM_PAY  = RW'(PAYLOAD_BYTES);
  localparam logic [RW-1:0] REM_TWO  = RW'(2);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);
  localparam logic [7:0]    GAP_LAST = (IPG_CYCLES == 0) ? 8'd0 : 8'(IPG_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SYNC, S_PID, S_ND, S_DATA, S_CRC, S_EOP, S_EOPW, S_GAP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    pid_q;
  logic [RW-1:0] rem, rem_d;
  logic [7:0]    gap_cnt, gap_d;
  logic          set_underrun;
  logic          pid_ok;
  logic          src_empty;
  logic [7:0]    src_data;
  logic          xfer;

  assign pid_ok = (pid_data[7:4] == ~pid_data[3:0]) && (pid_data[1:0] != 2'b00);
  assign busy   = (state != S_IDLE);

  always_comb begin
    src_empty = 1'b1;
    src_data  = 8'h00;
    case (state)
      S_ND:    begin src_empty = nd_empty;   src_data = nd_data;   end
      S_DATA:  begin src_empty = data_empty; src_data = data_data; end
      S_CRC:   begin src_empty = crc_empty;  src_data = crc_data;  end
      default: ;
    endcase
  end

  assign xfer = !src_empty && tx_ready;

  always_comb begin
    state_d      = state;
    rem_d        = rem;
    gap_d        = gap_cnt;
    tx_byte      = 8'h00;
    tx_valid     = 1'b0;
    tx_eop       = 1'b0;
    pid_pop      = 1'b0;
    nd_pop       = 1'b0;
    data_pop     = 1'b0;
    crc_pop      = 1'b0;
    pid_err      = 1'b0;
    set_underrun = 1'b0;
    case (state)
      S_IDLE: if (pkt_req && !pid_empty) state_d = S_CHECK;
      S_CHECK: begin
        if (pid_empty) begin
          state_d = S_IDLE;
        end else begin
          pid_pop = 1'b1;
          pid_err = !pid_ok;
          state_d = pid_ok ? S_SYNC : S_IDLE;
        end
      end
      S_SYNC: begin
        tx_byte  = SYNC_BYTE;
        tx_valid = 1'b1;
        if (tx_ready) state_d = S_PID;
      end
      S_PID: begin
        tx_byte  = pid_q;
        tx_valid = 1'b1;
        if (tx_ready) begin
          case (pid_q[1:0])
            2'b01:   begin state_d = S_ND;   rem_d = REM_TWO; end
            2'b11:   begin state_d = S_DATA; rem_d = REM_PAY; end
            default: state_d = S_EOP;
          endcase
        end
      end
      S_ND, S_DATA, S_CRC: begin
        tx_byte  = src_data;
        tx_valid = !src_empty;
        nd_pop   = (state == S_ND)   && xfer;
        data_pop = (state == S_DATA) && xfer;
        crc_pop  = (state == S_CRC)  && xfer;
        if (xfer) begin
          rem_d = rem - 1'b1;
          if (rem == REM_ONE) begin
            if (state == S_DATA) begin
              state_d = S_CRC;
              rem_d   = REM_TWO;
            end else begin
              state_d = S_EOP;
            end
          end
        end else if (tx_ready) begin
          // Source ran dry: still close the packet so the bus sees an EOP.
          set_underrun = 1'b1;
          state_d      = S_EOP;
        end
      end
      S_EOP: begin
        tx_eop  = 1'b1;
        state_d = S_EOPW;
      end
      S_EOPW: begin
        if (eop_done) begin
          gap_d   = 8'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
        else                     gap_d   = gap_cnt + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pid_q        <= 8'h00;
      rem          <= '0;
      gap_cnt      <= 8'd0;
      underrun_err <= 1'b0;
    end else begin
      state   <= state_d;
      rem     <= rem_d;
      gap_cnt <= gap_d;
      if (state == S_CHECK && !pid_empty && pid_ok) pid_q <= pid_data;
      if (set_underrun) underrun_err <= 1'b1;
    end
  end

`ifdef TX_SEQ_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              pkt_count <= 16'h0000;
    else if (state == S_EOPW && eop_done) pkt_count <= pkt_count + 16'h0001;
  end
`else
  assign pkt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: FIFO models, serializer model, byte log and scalar checks.
module tb_usb_tx_sequencer;
`ifdef TX_SEQ_PKT_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pkt_req = 1'b0, tx_ready = 1'b1, eop_done = 1'b0;
  logic pid_empty, nd_empty, data_empty, crc_empty;
  logic [7:0] pid_data, nd_data, data_data, crc_data, tx_byte;
  logic pid_pop, nd_pop, data_pop, crc_pop, tx_valid, tx_eop, busy, pid_err, underrun_err;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.PAYLOAD_BYTES(16), .SYNC_BYTE(8'h80), .IPG_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .pkt_req(pkt_req),
    .pid_empty(pid_empty), .pid_data(pid_data), .pid_pop(pid_pop),
    .nd_empty(nd_empty), .nd_data(nd_data), .nd_pop(nd_pop),
    .data_empty(data_empty), .data_data(data_data), .data_pop(data_pop),
    .crc_empty(crc_empty), .crc_data(crc_data), .crc_pop(crc_pop),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_eop(tx_eop),
    .eop_done(eop_done), .busy(busy), .pid_err(pid_err),
    .underrun_err(underrun_err), .pkt_count(pkt_count)
  );

  // Show-ahead FIFO models: 0=pid 1=nd 2=data 3=crc
  logic [7:0] mem [4][32];
  int wr [4] = '{0, 0, 0, 0};
  int rd [4] = '{0, 0, 0, 0};
  assign pid_empty  = (rd[0] == wr[0]);
  assign nd_empty   = (rd[1] == wr[1]);
  assign data_empty = (rd[2] == wr[2]);
  assign crc_empty  = (rd[3] == wr[3]);
  assign pid_data   = mem[0][rd[0][4:0]];
  assign nd_data    = mem[1][rd[1][4:0]];
  assign data_data  = mem[2][rd[2][4:0]];
  assign crc_data   = mem[3][rd[3][4:0]];

  always @(posedge clk) begin
    if (pid_pop)  rd[0] <= rd[0] + 1;
    if (nd_pop)   rd[1] <= rd[1] + 1;
    if (data_pop) rd[2] <= rd[2] + 1;
    if (crc_pop)  rd[3] <= rd[3] + 1;
  end

  task automatic push(input int f, input logic [7:0] b);
    mem[f][wr[f][4:0]] = b;
    wr[f] = wr[f] + 1;
  endtask

  task automatic flush();
    for (int f = 0; f < 4; f++) wr[f] = rd[f];
  endtask

  // Monitor on the falling edge, away from the state update
  logic [7:0] tx_log [256];
  int cyc = 0, tx_n = 0, last_xfer_cyc = 0, eop_cyc = 0, done_cyc = 0, pidpop_cyc = 0;
  int pidpop_n = 0, ndpop_n = 0, datapop_n = 0, crcpop_n = 0, eop_n = 0, done_n = 0;
  int piderr_n = 0, hold_err = 0;
  logic stall_prev = 1'b0;
  logic [7:0] byte_prev = 8'h00;

  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (stall_prev && (!tx_valid || tx_byte != byte_prev)) hold_err = hold_err + 1;
    stall_prev = tx_valid && !tx_ready;
    byte_prev  = tx_byte;
    if (tx_valid && tx_ready) begin
      if (tx_n < 256) tx_log[tx_n] = tx_byte;
      tx_n = tx_n + 1;
      last_xfer_cyc = cyc;
    end
    if (pid_pop)  begin pidpop_n = pidpop_n + 1; pidpop_cyc = cyc; end
    if (nd_pop)   ndpop_n   = ndpop_n + 1;
    if (data_pop) datapop_n = datapop_n + 1;
    if (crc_pop)  crcpop_n  = crcpop_n + 1;
    if (tx_eop)   begin eop_n = eop_n + 1; eop_cyc = cyc; end
    if (eop_done) begin done_n = done_n + 1; done_cyc = cyc; end
    if (pid_err)  piderr_n = piderr_n + 1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serializer model answers each tx_eop with a one-cycle eop_done on the next clock
  logic tog = 1'b0;
  int eop_hnd = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    eop_done = 1'b0;
    if (eop_n != eop_hnd) begin
      eop_hnd  = eop_n;
      eop_done = 1'b1;
    end
    if (tog) tx_ready = ~tx_ready;
  endtask

  function automatic int cur(input int which);
    case (which)
      0: return done_n;
      1: return pidpop_n;
      default: return datapop_n;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int target);
    int i;
    for (i = 0; i < 400; i++) begin
      if (cur(which) >= target) break;
      tick();
    end
    if (i == 400) chk({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  int b, b_nd, b_dp, b_cp, b_eop, b_pp, b_pe, b_dn, d0;
  logic [7:0] exp_bytes [20];

  task automatic snap();
    b = tx_n; b_nd = ndpop_n; b_dp = datapop_n; b_cp = crcpop_n;
    b_eop = eop_n; b_pp = pidpop_n; b_pe = piderr_n; b_dn = done_n;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_eop", tx_eop, 0);
    chk("rst_pops", {pid_pop, nd_pop, data_pop, crc_pop}, 0);
    chk("rst_underrun", underrun_err, 0);
    chk("rst_count", pkt_count, 0);
    rst = 1'b0;
    tick();

    // Handshake packet
    snap();
    push(0, 8'hD2);
    pkt_req = 1'b1;
    wait_cnt("hs", 0, b_dn + 1);
    repeat (4) tick();
    chk("hs_nbytes", tx_n - b, 2);
    chk("hs_sync", tx_log[b], 8'h80);
    chk("hs_pid", tx_log[b+1], 8'hD2);
    chk("hs_eop_lat", eop_cyc - last_xfer_cyc, 1);
    chk("hs_nopops", (ndpop_n - b_nd) + (datapop_n - b_dp) + (crcpop_n - b_cp), 0);
    chk("hs_count", pkt_count, CNT_ON ? 1 : 0);

    // Token packet with toggling ready
    snap();
    push(1, 8'h15); push(1, 8'hA8); push(0, 8'hE1);
    tog = 1'b1;
    wait_cnt("tok", 0, b_dn + 1);
    tog = 1'b0; tx_ready = 1'b1;
    repeat (4) tick();
    chk("tok_nbytes", tx_n - b, 4);
    chk("tok_b0", tx_log[b], 8'h80);
    chk("tok_b1", tx_log[b+1], 8'hE1);
    chk("tok_b2", tx_log[b+2], 8'h15);
    chk("tok_b3", tx_log[b+3], 8'hA8);
    chk("tok_ndpops", ndpop_n - b_nd, 2);
    chk("tok_hold", hold_err, 0);

    // Data packet, full payload
    snap();
    exp_bytes[0] = 8'h80; exp_bytes[1] = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      push(2, 8'(i));
      exp_bytes[i+2] = 8'(i);
    end
    exp_bytes[18] = 8'h5A; exp_bytes[19] = 8'h3C;
    push(3, 8'h5A); push(3, 8'h3C); push(0, 8'hC3);
    wait_cnt("data", 0, b_dn + 1);
    repeat (4) tick();
    chk("data_nbytes", tx_n - b, 20);
    for (int i = 0; i < 20; i++) chk($sformatf("data_b%0d", i), tx_log[b+i], exp_bytes[i]);
    chk("data_pops", datapop_n - b_dp, 16);
    chk("data_crcpops", crcpop_n - b_cp, 2);
    chk("data_eops", eop_n - b_eop, 1);
    chk("data_underrun", underrun_err, 0);

    // Invalid PID
    snap();
    push(0, 8'h33);
    wait_cnt("bad", 1, b_pp + 1);
    repeat (5) tick();
    chk("bad_piderr", piderr_n - b_pe, 1);
    chk("bad_pidpops", pidpop_n - b_pp, 1);
    chk("bad_nobytes", tx_n - b, 0);
    chk("bad_noeop", eop_n - b_eop, 0);
    chk("bad_idle", busy, 0);

    // Underrun: 5 payload bytes only
    snap();
    for (int i = 0; i < 5; i++) push(2, 8'hA0 + 8'(i));
    push(0, 8'hC3);
    wait_cnt("ur", 0, b_dn + 1);
    repeat (4) tick();
    chk("ur_nbytes", tx_n - b, 7);
    chk("ur_last", tx_log[b+6], 8'hA4);
    chk("ur_flag", underrun_err, 1);
    chk("ur_eops", eop_n - b_eop, 1);
    chk("ur_nocrc", crcpop_n - b_cp, 0);

    // Back-to-back handshakes: inter-packet gap
    snap();
    push(0, 8'hD2); push(0, 8'hD2);
    wait_cnt("ipg1", 0, b_dn + 1);
    d0 = done_cyc;
    wait_cnt("ipg_pop", 1, b_pp + 2);
    chk("ipg_gap", pidpop_cyc - d0, 4);
    wait_cnt("ipg2", 0, b_dn + 2);
    repeat (4) tick();
    chk("ipg_nbytes", tx_n - b, 4);
    chk("ur_sticky", underrun_err, 1);
    chk("ipg_count", pkt_count, CNT_ON ? 6 : 0);

    // Reset mid-DATA
    snap();
    for (int i = 0; i < 16; i++) push(2, 8'h40 + 8'(i));
    push(3, 8'h11); push(3, 8'h22); push(0, 8'hC3);
    wait_cnt("mid", 2, b_dp + 3);
    rst = 1'b1;
    pkt_req = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_valid", tx_valid, 0);
    chk("mid_byte", tx_byte, 8'h00);
    chk("mid_pops", {pid_pop, nd_pop, data_pop, crc_pop}, 0);
    chk("mid_underrun", underrun_err, 0);
    chk("mid_count", pkt_count, 0);
    chk("mid_noeop", eop_n - b_eop, 0);
    rst = 1'b0;
    flush();
    repeat (3) tick();
    chk("mid_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
